timer_counter: RTL
==================

TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameters: none; the counter width is fixed at 32 bits and the register map is fixed.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 addr  input  30  word address [31:2] from bridge; only addr[3:2] is decoded.
REQ-005 we  input  1  write strobe; already qualified by bridge address decode.
REQ-006 wdata  input  32  write data.
REQ-007 rdata  output  32  combinational read data for the selected register.
REQ-008 irq  output  1  interrupt request to the CPU interrupt source; registered.

Function
REQ-009 Register map by addr[3:2]: 0 = CTRL (R/W), 1 = PRESET (R/W), 2 = COUNT (read-only), 3 = reserved (reads 0).
REQ-010 CTRL[0] = EN, CTRL[2:1] = MODE, CTRL[3] = IM (interrupt mask); bits [31:4] ignore writes and read 0.
REQ-011 MODE 0 = one-shot; MODE 1 = auto-reload; MODE 2 and 3 behave as MODE 0.
REQ-012 Writes with addr[3:2] = 2 or 3 have no effect.
REQ-013 The FSM has four states: IDLE, LOAD, CNT, INT.
REQ-014 IDLE: EN = 1 -> LOAD; otherwise stay in IDLE.
REQ-015 LOAD: COUNT <= PRESET, then -> CNT.
REQ-016 CNT with EN = 0: -> IDLE; COUNT holds its value.
REQ-017 CNT with EN = 1 and COUNT > 1: COUNT <= COUNT - 1.
REQ-018 CNT with EN = 1 and COUNT <= 1: COUNT <= 0, irq_flag <= 1, then -> INT.
REQ-019 INT in MODE 0: clear EN, then -> IDLE; irq_flag stays set.
REQ-020 INT in MODE 1: EN is unchanged, irq_flag <= 0, then -> IDLE; this reloads the count, giving a period of PRESET + 3 cycles.
REQ-021 irq = irq_flag AND IM.
REQ-022 irq_flag clears on any bus write to CTRL or PRESET.
REQ-023 Latency: a write with EN = 1 at edge 0, PRESET = P >= 1, drives irq high after edge P+2.
REQ-024 P = 0 behaves as P = 1.
REQ-025 A PRESET write during CNT does not change COUNT; the new value applies at the next LOAD.
REQ-026 A bus write to CTRL in the same cycle as the INT-state EN clear: the bus write wins.
REQ-027 A bus write to CTRL in the same cycle as the irq_flag set: the clear wins, so irq_flag = 0.
REQ-028 COUNT never wraps below 0.
REQ-029 rdata depends only on addr and current register values; there is no read side effect.

Reset
REQ-030 reset low asynchronously forces CTRL = 0, PRESET = 0, COUNT = 0, irq_flag = 0, state = IDLE, irq = 0, rdata = 0 for any addr.
REQ-031 reset asserted mid-count abandons the count; after release the block stays in IDLE until EN is written.

Structure
REQ-032 Register offsets, CTRL bit positions, MODE codes and state encodings live in a shared include next to the bridge constants (TC_Consts.v).
REQ-033 Single flat module with no sub-module; two instances (TC0, TC1) are placed at system level.

Verification
REQ-034 P = 5, write CTRL = 0x9 (MODE 0, IM = 1, EN = 1) at edge 0 -> irq rises after edge 7 and holds; CTRL reads 0x8; COUNT reads 0.
REQ-035 P = 3, CTRL = 0xB (MODE 1) -> irq is a 1-cycle pulse every 6 cycles; EN stays 1.
REQ-036 MODE 0 fired, then write CTRL = 0x8 -> irq drops the next cycle; the state stays IDLE.
REQ-037 P = 10, clear EN after 4 CNT cycles -> COUNT freezes at 6 and irq stays 0; re-enable -> reload to 10.
REQ-038 IM = 0, P = 2, MODE 0 -> irq stays 0 while COUNT reaches 0; then write CTRL = 0x8 -> irq stays 0 (flag cleared).
REQ-039 Pull reset low mid-count at COUNT = 3 -> all registers read 0 immediately, irq = 0, and no irq after release.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared constants and types for the 32-bit timer/counter: register offsets,
// CTRL field layout, MODE codes and FSM state encoding.
package timer_counter_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  localparam int CTRL_W = 4;

  // Field order places EN at bit 0, MODE at [2:1], IM at bit 3.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  // MODE 2 and 3 fall back to one-shot behaviour.
  function automatic logic is_reload(input ctrl_t c);
    return c.mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Register bus between the bridge and a timer_counter instance, plus its irq line.
interface timer_counter_if;
  logic [31:2] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, output we, output wdata, input rdata, input irq);
  modport slave  (input addr, input we, input wdata, output rdata, output irq);
endinterface

// File: rtl/timer_counter.sv
// 32-bit down-counting timer with CTRL/PRESET/COUNT registers and a masked,
// registered interrupt; one-shot or auto-reload, combinational read-back.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus
);

  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_flag_q, irq_flag_d;
  logic        irq_q;
  tc_state_e   state_q;

  logic [1:0]  sel;
  logic        wr_ctrl, wr_preset;
  logic        fire, int_reload, int_oneshot;
  logic        unused_addr;

  assign sel         = bus.addr[3:2];
  assign unused_addr = ^bus.addr[31:4];
  assign wr_ctrl     = bus.we && (sel == REG_CTRL);
  assign wr_preset   = bus.we && (sel == REG_PRESET);
  assign fire        = (state_q == ST_CNT) && ctrl_q.en && (count_q <= 32'd1);
  assign int_reload  = (state_q == ST_INT) && is_reload(ctrl_q);
  assign int_oneshot = (state_q == ST_INT) && !is_reload(ctrl_q);

  // A bus write to CTRL overrides the one-shot EN clear in the same cycle.
  always_comb begin
    ctrl_d = ctrl_q;
    if (int_oneshot) ctrl_d.en = 1'b0;
    if (wr_ctrl)     ctrl_d = ctrl_t'(bus.wdata[CTRL_W-1:0]);
  end

  // Bus-write clear has the final say over a simultaneous set.
  always_comb begin
    irq_flag_d = irq_flag_q;
    if (fire)                   irq_flag_d = 1'b1;
    if (int_reload)             irq_flag_d = 1'b0;
    if (wr_ctrl || wr_preset)   irq_flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      ctrl_q     <= ctrl_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_flag_d & ctrl_d.im;
      if (wr_preset) preset_q <= bus.wdata;
      case (state_q)
        ST_IDLE: if (ctrl_q.en) state_q <= ST_LOAD;
        ST_LOAD: begin
          count_q <= preset_q;
          state_q <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl_q.en) begin
            state_q <= ST_IDLE;
          end else if (fire) begin
            count_q <= '0;
            state_q <= ST_INT;
          end else begin
            count_q <= count_q - 32'd1;
          end
        end
        ST_INT:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (sel)
      REG_CTRL:   bus.rdata = {28'd0, ctrl_q};
      REG_PRESET: bus.rdata = preset_q;
      REG_COUNT:  bus.rdata = count_q;
      default:    bus.rdata = '0;
    endcase
  end

  assign bus.irq = irq_q;

endmodule
